// File: rtl/local_bht_predictor.sv
// Two-level local-history branch direction predictor: per-slot BHT/PHT banks,
// one-cycle registered block prediction, single-cycle training, init walk after reset.
module local_bht_predictor #(
    parameter int         FETCH_WIDTH   = 4,
    parameter int         BHT_DEPTH     = 256,
    parameter int         HIST_LEN      = 10,
    parameter int         PHT_IDX_BITS  = 8,
    parameter int         PHT_HIST_BITS = 4,
    parameter logic [1:0] CTR_INIT      = 2'b01,
    localparam int        SLOT_W        = (FETCH_WIDTH > 1) ? $clog2(FETCH_WIDTH) : 1
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   req_valid,
    input  logic [31:0]            req_pc,
    output logic                   pred_valid,
    output logic [FETCH_WIDTH-1:0] pred_taken,
    output logic                   pred_any,
    output logic [SLOT_W-1:0]      pred_slot,
    input  logic                   upd_valid,
    input  logic [31:0]            upd_pc,
    input  logic                   upd_taken,
    output logic                   ready
);

    localparam int B         = $clog2(FETCH_WIDTH);
    localparam int BHT_IW    = (BHT_DEPTH > 1) ? $clog2(BHT_DEPTH) : 1;
    localparam int PHT_DEPTH = 1 << PHT_IDX_BITS;
    localparam int PC_BITS   = PHT_IDX_BITS - PHT_HIST_BITS;
    localparam int WALK_N    = (BHT_DEPTH > PHT_DEPTH) ? BHT_DEPTH : PHT_DEPTH;
    localparam int WALK_W    = (WALK_N > 1) ? $clog2(WALK_N) : 1;

    typedef enum logic {
        S_INIT,
        S_READY
    } state_t;

    state_t              state_q, state_d;
    logic [WALK_W-1:0]   walk_cnt_q, walk_cnt_d;

    logic [HIST_LEN-1:0] bht_mem [0:FETCH_WIDTH-1][0:BHT_DEPTH-1];
    logic [1:0]          pht_mem [0:FETCH_WIDTH-1][0:PHT_DEPTH-1];

    function automatic logic [SLOT_W-1:0] slot_of(input logic [31:0] pc);
        logic [31:0] s;
        s = (pc >> 2) & 32'(FETCH_WIDTH - 1);
        return s[SLOT_W-1:0];
    endfunction

    function automatic logic [BHT_IW-1:0] bht_idx_of(input logic [31:0] pc);
        logic [31:0] s;
        s = pc >> (2 + B);
        return s[BHT_IW-1:0];
    endfunction

    function automatic logic [PHT_IDX_BITS-1:0] pht_idx_of(input logic [HIST_LEN-1:0] bhr,
                                                          input logic [31:0]         pc);
        logic [31:0] s;
        s = pc >> (2 + B);
        return {bhr[PHT_HIST_BITS-1:0], s[PC_BITS-1:0]};
    endfunction

    function automatic logic [1:0] sat_ctr(input logic [1:0] c, input logic taken);
        if (taken)
            return (c == 2'd3) ? 2'd3 : c + 2'd1;
        else
            return (c == 2'd0) ? 2'd0 : c - 2'd1;
    endfunction

    // Init walk FSM
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= S_INIT;
            walk_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            walk_cnt_q <= walk_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        walk_cnt_d = walk_cnt_q;
        case (state_q)
            S_INIT: begin
                walk_cnt_d = walk_cnt_q + 1'b1;
                if (walk_cnt_q == WALK_W'(WALK_N - 1)) begin
                    state_d    = S_READY;
                    walk_cnt_d = '0;
                end
            end
            S_READY: begin
                state_d = S_READY;
            end
            default: begin
                state_d = S_INIT;
            end
        endcase
    end

    assign ready = (state_q == S_READY);

    // Stage p0: combinational lookup of the whole fetch block
    logic                   vld_p0;
    logic [SLOT_W-1:0]      req_slot_p0;
    logic [BHT_IW-1:0]      req_bht_idx_p0;
    logic [FETCH_WIDTH-1:0] taken_p0;
    logic [SLOT_W-1:0]      first_slot_p0;

    assign vld_p0         = req_valid && ready;
    assign req_slot_p0    = slot_of(req_pc);
    assign req_bht_idx_p0 = bht_idx_of(req_pc);

    always_comb begin
        logic [HIST_LEN-1:0] bhr_b;
        logic [1:0]          ctr_b;
        taken_p0 = '0;
        bhr_b    = '0;
        ctr_b    = '0;
        for (int b = 0; b < FETCH_WIDTH; b++) begin
            bhr_b = bht_mem[b][req_bht_idx_p0];
            ctr_b = pht_mem[b][pht_idx_of(bhr_b, req_pc)];
            if (b >= int'(req_slot_p0))
                taken_p0[b] = ctr_b[1];
        end
    end

    always_comb begin
        first_slot_p0 = '0;
        for (int b = FETCH_WIDTH - 1; b >= 0; b--) begin
            if (taken_p0[b])
                first_slot_p0 = SLOT_W'(b);
        end
    end

    // Update path: read current BHR/counter, write back next edge
    logic                    upd_fire;
    logic [SLOT_W-1:0]       upd_slot;
    logic [BHT_IW-1:0]       upd_bht_idx;
    logic [HIST_LEN-1:0]     upd_bhr;
    logic [PHT_IDX_BITS-1:0] upd_pht_idx;
    logic [1:0]              upd_ctr;

    assign upd_fire    = upd_valid && ready;
    assign upd_slot    = slot_of(upd_pc);
    assign upd_bht_idx = bht_idx_of(upd_pc);
    assign upd_bhr     = bht_mem[upd_slot][upd_bht_idx];
    assign upd_pht_idx = pht_idx_of(upd_bhr, upd_pc);
    assign upd_ctr     = pht_mem[upd_slot][upd_pht_idx];

    always_ff @(posedge clk) begin
        if (state_q == S_INIT) begin
            for (int b = 0; b < FETCH_WIDTH; b++) begin
                if (int'(walk_cnt_q) < BHT_DEPTH)
                    bht_mem[b][walk_cnt_q[BHT_IW-1:0]] <= '0;
                if (int'(walk_cnt_q) < PHT_DEPTH)
                    pht_mem[b][walk_cnt_q[PHT_IDX_BITS-1:0]] <= CTR_INIT;
            end
        end else if (upd_fire) begin
            bht_mem[upd_slot][upd_bht_idx] <= {upd_bhr[HIST_LEN-2:0], upd_taken};
            pht_mem[upd_slot][upd_pht_idx] <= sat_ctr(upd_ctr, upd_taken);
        end
    end

    // Stage p1: registered prediction
    logic                   vld_p1;
    logic [FETCH_WIDTH-1:0] taken_p1;
    logic                   any_p1;
    logic [SLOT_W-1:0]      slot_p1;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            vld_p1   <= 1'b0;
            taken_p1 <= '0;
            any_p1   <= 1'b0;
            slot_p1  <= '0;
        end else begin
            vld_p1   <= vld_p0;
            taken_p1 <= vld_p0 ? taken_p0 : '0;
            any_p1   <= vld_p0 && (|taken_p0);
            slot_p1  <= vld_p0 ? first_slot_p0 : '0;
        end
    end

    assign pred_valid = vld_p1;
    assign pred_taken = taken_p1;
    assign pred_any   = any_p1;
    assign pred_slot  = slot_p1;

endmodule

// File: tb/tb_local_bht_predictor.sv
// Self-checking bench for local_bht_predictor: directed scenarios plus randomized
// traffic against an array-based reference model of the predictor tables.
module tb_local_bht_predictor;

    localparam int FW    = 4;
    localparam int ROWS  = 256;
    localparam int HMOD  = 1024;
    localparam int LAT   = 256;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        req_valid = 1'b0;
    logic [31:0] req_pc = '0;
    logic        pred_valid;
    logic [3:0]  pred_taken;
    logic        pred_any;
    logic [1:0]  pred_slot;
    logic        upd_valid = 1'b0;
    logic [31:0] upd_pc = '0;
    logic        upd_taken = 1'b0;
    logic        ready;

    local_bht_predictor dut (
        .clk        (clk),
        .resetn     (resetn),
        .req_valid  (req_valid),
        .req_pc     (req_pc),
        .pred_valid (pred_valid),
        .pred_taken (pred_taken),
        .pred_any   (pred_any),
        .pred_slot  (pred_slot),
        .upd_valid  (upd_valid),
        .upd_pc     (upd_pc),
        .upd_taken  (upd_taken),
        .ready      (ready)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference tables: history value and counter value per (bank, row)
    int m_bhr [FW][ROWS];
    int m_ctr [FW][ROWS];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
        end
    endtask

    function automatic void model_clear();
        for (int b = 0; b < FW; b++)
            for (int i = 0; i < ROWS; i++) begin
                m_bhr[b][i] = 0;
                m_ctr[b][i] = 1;
            end
    endfunction

    function automatic int pht_row(input int hist, input logic [31:0] pc);
        return (hist % 16) * 16 + int'((pc / (4 * FW)) % 16);
    endfunction

    function automatic logic [3:0] model_predict(input logic [31:0] pc);
        logic [3:0] p;
        int slot;
        int row;
        p    = '0;
        slot = int'((pc / 4) % FW);
        row  = int'((pc / (4 * FW)) % ROWS);
        for (int b = 0; b < FW; b++)
            if (b >= slot && m_ctr[b][pht_row(m_bhr[b][row], pc)] >= 2)
                p[b] = 1'b1;
        return p;
    endfunction

    function automatic void model_update(input logic [31:0] pc, input bit t);
        int slot;
        int row;
        int pr;
        slot = int'((pc / 4) % FW);
        row  = int'((pc / (4 * FW)) % ROWS);
        pr   = pht_row(m_bhr[slot][row], pc);
        if (t) m_ctr[slot][pr] = (m_ctr[slot][pr] < 3) ? m_ctr[slot][pr] + 1 : 3;
        else   m_ctr[slot][pr] = (m_ctr[slot][pr] > 0) ? m_ctr[slot][pr] - 1 : 0;
        m_bhr[slot][row] = (m_bhr[slot][row] * 2 + int'(t)) % HMOD;
    endfunction

    function automatic logic [1:0] lowest(input logic [3:0] p);
        for (int b = 0; b < FW; b++)
            if (p[b]) return 2'(b);
        return 2'd0;
    endfunction

    // One clock of traffic in READY; checks the registered result against the model
    task automatic cycle(input bit rq, input logic [31:0] rpc, input bit uq,
                         input logic [31:0] upc, input bit ut, input string tag);
        logic [3:0] exp_t;
        req_valid = rq;
        req_pc    = rpc;
        upd_valid = uq;
        upd_pc    = upc;
        upd_taken = ut;
        exp_t     = model_predict(rpc);
        @(posedge clk);
        if (uq) model_update(upc, ut);
        #1;
        chk({tag, ".vld"}, 32'(pred_valid), 32'(rq));
        if (rq) begin
            chk({tag, ".taken"}, 32'(pred_taken), 32'(exp_t));
            chk({tag, ".any"}, 32'(pred_any), 32'(|exp_t));
            chk({tag, ".slot"}, 32'(pred_slot), 32'(lowest(exp_t)));
        end
        req_valid = 1'b0;
        upd_valid = 1'b0;
    endtask

    task automatic wait_ready(output int edges);
        edges = -1;
        for (int i = 1; i <= 400; i++) begin
            @(posedge clk);
            #1;
            if (ready) begin
                edges = i;
                break;
            end
        end
    endtask

    initial begin
        int edges;
        bit rq, uq, ut;
        logic [31:0] rpc, upc;

        model_clear();
        repeat (3) @(posedge clk);
        #1;
        chk("rst.ready", 32'(ready), 32'd0);
        chk("rst.pred_valid", 32'(pred_valid), 32'd0);
        chk("rst.pred_taken", 32'(pred_taken), 32'd0);
        chk("rst.pred_any", 32'(pred_any), 32'd0);
        chk("rst.pred_slot", 32'(pred_slot), 32'd0);

        // Init walk with lookups and updates that must all be ignored
        resetn = 1'b1;
        for (int i = 1; i <= LAT; i++) begin
            req_valid = 1'b1;
            req_pc    = 32'h100;
            upd_valid = (i <= 5) || (i == LAT);
            upd_pc    = 32'h100;
            upd_taken = 1'b1;
            @(posedge clk);
            #1;
            chk("init.pred_valid", 32'(pred_valid), 32'd0);
            chk("init.ready", 32'(ready), 32'(i == LAT));
        end
        req_valid = 1'b0;
        upd_valid = 1'b0;

        cycle(1, 32'h100, 0, 32'h0, 0, "post_init");
        chk("post_init.const", 32'(pred_taken), 32'h0);

        for (int k = 0; k < 4; k++)
            cycle(0, 32'h0, 1, 32'h100, 1, "train0");
        cycle(1, 32'h100, 1, 32'h100, 1, "rbw_same");
        chk("rbw_same.const", 32'(pred_taken), 32'h0);
        cycle(1, 32'h100, 0, 32'h0, 0, "rbw_next");
        chk("rbw_next.const", 32'(pred_taken), 32'h1);
        chk("rbw_next.any", 32'(pred_any), 32'd1);

        for (int k = 0; k < 5; k++)
            cycle(0, 32'h0, 1, 32'h104, 1, "train1");
        cycle(1, 32'h100, 0, 32'h0, 0, "mask100");
        chk("mask100.const", 32'(pred_taken), 32'h3);
        cycle(1, 32'h104, 0, 32'h0, 0, "mask104");
        chk("mask104.const", 32'(pred_taken), 32'h2);
        chk("mask104.slot", 32'(pred_slot), 32'd1);
        cycle(1, 32'h108, 0, 32'h0, 0, "mask108");
        chk("mask108.const", 32'(pred_taken), 32'h0);

        // Randomized traffic over a small PC window so entries saturate and histories wrap
        for (int k = 0; k < 600; k++) begin
            rq  = 1'($urandom_range(0, 1));
            uq  = ($urandom_range(0, 3) != 0);
            ut  = ($urandom_range(0, 3) != 0);
            rpc = 32'h1000 + 32'($urandom_range(0, 31)) * 4;
            upc = 32'h1000 + 32'($urandom_range(0, 31)) * 4;
            if (k % 50 == 0) begin
                rpc = 32'h1000;
                upc = 32'h1000;
            end
            cycle(rq, rpc, uq, upc, ut, "rand");
        end

        // Reset in the middle of operation
        cycle(1, 32'h100, 0, 32'h0, 0, "pre_rst");
        resetn = 1'b0;
        #1;
        chk("midrst.pred_valid", 32'(pred_valid), 32'd0);
        chk("midrst.pred_taken", 32'(pred_taken), 32'd0);
        chk("midrst.pred_any", 32'(pred_any), 32'd0);
        chk("midrst.pred_slot", 32'(pred_slot), 32'd0);
        chk("midrst.ready", 32'(ready), 32'd0);
        @(posedge clk);
        #1;
        resetn = 1'b1;
        model_clear();
        wait_ready(edges);
        chk("midrst.ready_latency", 32'(edges), 32'(LAT));
        cycle(1, 32'h100, 0, 32'h0, 0, "post_rst");
        chk("post_rst.const", 32'(pred_taken), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
